// File: rtl/bool_seq_pkg.sv
// Shared definitions for the boolean truth-table sequencer: FSM state
// encoding and the vector-count helper used to size table ports.
package bool_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int N_IN_DEFAULT = 3;

  // Number of input vectors swept for an N-input boolean block.
  function automatic int vec_count(input int n_in);
    return 1 << n_in;
  endfunction

endpackage

// File: rtl/bool_tt_popcount.sv
// Combinational population count of a truth-table-wide bit vector.
// The result is N_IN+1 bits so a fully set table (all V bits) fits.
module bool_tt_popcount
  import bool_seq_pkg::*;
#(
  parameter int N_IN = N_IN_DEFAULT
) (
  input  logic [vec_count(N_IN)-1:0] i_bits,
  output logic [N_IN:0]              o_count
);

  // Sum every set bit of the input vector.
  always_comb begin
    o_count = '0;
    for (int i = 0; i < vec_count(N_IN); i++) begin
      o_count = o_count + {{N_IN{1'b0}}, i_bits[i]};
    end
  end

endmodule

// File: rtl/bool_tt_sequencer.sv
// Stimulus/capture controller for a small combinational boolean block.
// Sweeps every input vector, holds each for SETTLE+1 cycles, samples the
// block output on the last cycle of each hold, builds the truth table and
// compares it against an expected table latched when the sweep starts.
module bool_tt_sequencer
  import bool_seq_pkg::*;
#(
  parameter int N_IN   = N_IN_DEFAULT,
  parameter int SETTLE = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [vec_count(N_IN)-1:0]  expected,
  input  logic                        d_i,
  output logic [N_IN-1:0]             vec_o,
  output logic                        busy,
  output logic                        done,
  output logic [vec_count(N_IN)-1:0]  table_o,
  output logic                        match,
  output logic [N_IN:0]               err_cnt
);

  localparam int V  = vec_count(N_IN);
  // Settle counter needs at least one bit even when SETTLE is zero.
  localparam int CW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [N_IN-1:0] r_vec;
  logic [N_IN-1:0] w_vec_nxt;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_nxt;
  logic [V-1:0]    r_table;
  logic [V-1:0]    w_table_nxt;
  logic [V-1:0]    w_table_fin;
  logic [V-1:0]    r_exp;
  logic [V-1:0]    w_exp_nxt;
  logic            r_busy;
  logic            w_busy_nxt;
  logic            r_done;
  logic            w_done_nxt;
  logic            r_match;
  logic            w_match_nxt;
  logic [N_IN:0]   r_err;
  logic [N_IN:0]   w_err_nxt;
  logic [N_IN:0]   w_popcnt;

  // Error count is taken on the table that already includes the final sample,
  // so the result is ready in the same cycle the sweep ends.
  bool_tt_popcount #(
    .N_IN (N_IN)
  ) u_popcount (
    .i_bits  (w_table_fin ^ r_exp),
    .o_count (w_popcnt)
  );

  // Next-state and next-register values for the sweep FSM.
  always_comb begin
    w_state_nxt = r_state;
    w_vec_nxt   = r_vec;
    w_cnt_nxt   = r_cnt;
    w_table_nxt = r_table;
    w_exp_nxt   = r_exp;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_match_nxt = r_match;
    w_err_nxt   = r_err;

    w_table_fin        = r_table;
    w_table_fin[r_vec] = d_i;

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_exp_nxt   = expected;
          w_vec_nxt   = '0;
          w_cnt_nxt   = '0;
          w_table_nxt = '0;
          w_match_nxt = 1'b0;
          w_err_nxt   = '0;
          w_busy_nxt  = 1'b1;
          w_state_nxt = ST_HOLD;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end

      ST_HOLD: begin
        if (r_cnt != CW'(SETTLE)) begin
          w_cnt_nxt = r_cnt + CW'(1);
        end else begin
          w_table_nxt = w_table_fin;
          w_cnt_nxt   = '0;
          if (r_vec != N_IN'(V - 1)) begin
            w_vec_nxt = r_vec + N_IN'(1);
          end else begin
            w_vec_nxt   = '0;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
            w_match_nxt = (w_table_fin == r_exp);
            w_err_nxt   = w_popcnt;
            w_state_nxt = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        // Single-cycle completion state; start is deliberately not sampled here.
        w_state_nxt = ST_IDLE;
      end

      default: begin
        w_busy_nxt  = 1'b0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and result registers; reset also discards any partial sweep.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_vec   <= '0;
      r_cnt   <= '0;
      r_table <= '0;
      r_exp   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_match <= 1'b0;
      r_err   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_vec   <= w_vec_nxt;
      r_cnt   <= w_cnt_nxt;
      r_table <= w_table_nxt;
      r_exp   <= w_exp_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_match <= w_match_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign vec_o   = r_vec;
  assign busy    = r_busy;
  assign done    = r_done;
  assign table_o = r_table;
  assign match   = r_match;
  assign err_cnt = r_err;

endmodule
